// File: rtl/stage_fetch.sv
// MIPS IF stage: PC, instruction memory, next-PC select and IF/ID register.
// Latches HALT on fetch and freezes the PC until a redirect arrives.
module stage_fetch #(
    parameter int                    DATA_SIZE  = 32,
    parameter int                    ADDR_SIZE  = 8,
    parameter int                    IMEM_DEPTH = 256,
    parameter logic [DATA_SIZE-1:0]  HALT_INSTR = 32'hFFFFFFFF
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_step_en,
    input  logic                 i_enable_pc,
    input  logic                 i_enable_IF_ID,
    input  logic                 i_flush_IF,
    input  logic                 i_branch_taken,
    input  logic [DATA_SIZE-1:0] i_branch_addr,
    input  logic                 i_jump,
    input  logic [DATA_SIZE-1:0] i_jump_addr,
    input  logic                 i_imem_wr_en,
    input  logic [ADDR_SIZE-1:0] i_imem_wr_addr,
    input  logic [DATA_SIZE-1:0] i_imem_wr_data,
    output logic [DATA_SIZE-1:0] o_pc,
    output logic [DATA_SIZE-1:0] o_instruction,
    output logic [DATA_SIZE-1:0] o_pc_plus4,
    output logic                 o_valid,
    output logic                 o_halted
);

    localparam logic [DATA_SIZE-1:0] FOUR = DATA_SIZE'(4);

    logic [DATA_SIZE-1:0] imem [IMEM_DEPTH];
    logic [DATA_SIZE-1:0] pc;
    logic [DATA_SIZE-1:0] pc_plus4;
    logic [DATA_SIZE-1:0] fetched;
    logic                 redirect;
    logic                 halt_hit;

    assign pc_plus4 = pc + FOUR;
    assign fetched  = imem[pc[ADDR_SIZE+1:2]];
    assign redirect = i_branch_taken | i_jump;
    assign o_pc     = pc;

    // HALT is being captured into IF/ID this cycle
    assign halt_hit = !o_halted && !i_flush_IF && i_enable_IF_ID
                    && !redirect && (fetched == HALT_INSTR);

    always_ff @(posedge i_clk) begin
        if (i_imem_wr_en)
            imem[i_imem_wr_addr] <= i_imem_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc            <= '0;
            o_instruction <= '0;
            o_pc_plus4    <= '0;
            o_valid       <= 1'b0;
            o_halted      <= 1'b0;
        end else if (i_step_en) begin
            if (i_branch_taken)
                pc <= i_branch_addr;
            else if (i_jump)
                pc <= i_jump_addr;
            else if (!o_halted && !halt_hit && i_enable_pc)
                pc <= pc_plus4;

            if (i_flush_IF || o_halted) begin
                o_instruction <= '0;
                o_pc_plus4    <= '0;
                o_valid       <= 1'b0;
            end else if (i_enable_IF_ID) begin
                o_instruction <= fetched;
                o_pc_plus4    <= pc_plus4;
                o_valid       <= 1'b1;
            end

            if (redirect)
                o_halted <= 1'b0;
            else if (halt_hit)
                o_halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch: stimulus pushes expected IF state,
// a monitor pops and compares one snapshot per clock edge.
module tb_stage_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic        halted;
    } exp_t;

    localparam logic [31:0] A  = 32'h20010005;
    localparam logic [31:0] B  = 32'h20020007;
    localparam logic [31:0] C  = 32'h20030001;
    localparam logic [31:0] D  = 32'h20040002;
    localparam logic [31:0] E  = 32'h20050003;
    localparam logic [31:0] F  = 32'h20060006;
    localparam logic [31:0] G  = 32'h20070007;
    localparam logic [31:0] H  = 32'hFFFFFFFF;
    localparam logic [31:0] W3 = 32'h12345678;
    localparam logic [31:0] W4 = 32'hAAAA0000;

    logic        clk;
    logic        rst_n;
    logic        step_en, en_pc, en_ifid, flush;
    logic        br, jmp;
    logic [31:0] br_addr, jmp_addr;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pc, instr, pp4;
    logic        valid, halted;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_edge   = 0;

    stage_fetch dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_step_en      (step_en),
        .i_enable_pc    (en_pc),
        .i_enable_IF_ID (en_ifid),
        .i_flush_IF     (flush),
        .i_branch_taken (br),
        .i_branch_addr  (br_addr),
        .i_jump         (jmp),
        .i_jump_addr    (jmp_addr),
        .i_imem_wr_en   (wr_en),
        .i_imem_wr_addr (wr_addr),
        .i_imem_wr_data (wr_data),
        .o_pc           (pc),
        .o_instruction  (instr),
        .o_pc_plus4     (pp4),
        .o_valid        (valid),
        .o_halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, exp_t e);
        n_checks++;
        if (pc === e.pc && instr === e.instr && pp4 === e.pp4
            && valid === e.valid && halted === e.halted) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h instr=%h pp4=%h v=%b h=%b, want pc=%h instr=%h pp4=%h v=%b h=%b",
                     name, pc, instr, pp4, valid, halted,
                     e.pc, e.instr, e.pp4, e.valid, e.halted);
        end
    endfunction

    function automatic exp_t mk(logic [31:0] p, logic [31:0] i,
                                logic [31:0] q, logic v, logic h);
        exp_t e;
        e.pc = p; e.instr = i; e.pp4 = q; e.valid = v; e.halted = h;
        return e;
    endfunction

    // Monitor: one expected snapshot per clock edge, sampled 1 time unit after
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_edge++;
            check($sformatf("cycle%0d", n_edge), e);
        end
    end

    task automatic defaults();
        step_en = 1'b1; en_pc = 1'b1; en_ifid = 1'b1; flush = 1'b0;
        br = 1'b0; jmp = 1'b0; br_addr = '0; jmp_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic cyc(exp_t e);
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        defaults();
    endtask

    function automatic logic [31:0] init_word(int a);
        case (a)
            0: return A;   1: return B;   2: return C;   3: return D;
            4: return E;   5: return H;  16: return F;  17: return G;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        defaults();
        rst_n = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            wr_en = 1'b1; wr_addr = 8'(a); wr_data = init_word(a);
            @(negedge clk);
        end
        defaults();
        check("reset", mk(0, 0, 0, 0, 0));
        rst_n = 1'b1;

        cyc(mk(32'h04, A, 32'h04, 1, 0));
        cyc(mk(32'h08, B, 32'h08, 1, 0));
        en_pc = 0; en_ifid = 0;
        cyc(mk(32'h08, B, 32'h08, 1, 0));
        en_pc = 0; en_ifid = 0;
        cyc(mk(32'h08, B, 32'h08, 1, 0));
        cyc(mk(32'h0C, C, 32'h0C, 1, 0));
        br = 1; br_addr = 32'h40; flush = 1;
        cyc(mk(32'h40, 0, 0, 0, 0));
        cyc(mk(32'h44, F, 32'h44, 1, 0));
        jmp = 1; jmp_addr = 32'h10;
        cyc(mk(32'h10, G, 32'h48, 1, 0));
        cyc(mk(32'h14, E, 32'h14, 1, 0));
        cyc(mk(32'h14, H, 32'h18, 1, 1));
        cyc(mk(32'h14, 0, 0, 0, 1));
        cyc(mk(32'h14, 0, 0, 0, 1));
        jmp = 1; jmp_addr = 32'h08;
        cyc(mk(32'h08, 0, 0, 0, 0));
        cyc(mk(32'h0C, C, 32'h0C, 1, 0));
        step_en = 0; wr_en = 1; wr_addr = 8'd3; wr_data = W3;
        cyc(mk(32'h0C, C, 32'h0C, 1, 0));
        cyc(mk(32'h10, W3, 32'h10, 1, 0));
        wr_en = 1; wr_addr = 8'd4; wr_data = W4;
        cyc(mk(32'h14, E, 32'h14, 1, 0));

        // Asynchronous reset between edges, after the monitor has sampled
        @(posedge clk);
        sb.push_back(mk(32'h14, H, 32'h18, 1, 1));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(mk(32'h04, A, 32'h04, 1, 0));
        cyc(mk(32'h08, B, 32'h08, 1, 0));
        cyc(mk(32'h0C, C, 32'h0C, 1, 0));
        cyc(mk(32'h10, W3, 32'h10, 1, 0));
        cyc(mk(32'h14, W4, 32'h14, 1, 0));

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
